// File: rtl/score_update_pkg.sv
// -----------------------------------------------------------------------------
// score_update_pkg
// Shared constants for the score_update block: the 2-bit match result codes
// and the default counter width / saturation value.
// -----------------------------------------------------------------------------
package score_update_pkg;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_DRAW = 2'b01;
    localparam logic [1:0] RES_WIN  = 2'b10;
    localparam logic [1:0] RES_LOSE = 2'b11;

    localparam int unsigned CNT_W_DEF   = 4;
    localparam int unsigned CNT_MAX_DEF = 15;

endpackage

// File: rtl/score_update_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one when inc is high and sticks at CNT_MAX
// instead of wrapping.
//
// Ports:
//   clk    in   1      rising-edge clock
//   resetn in   1      asynchronous reset, active HIGH despite the name
//   inc    in   1      increment request for this cycle
//   count  out  CNT_W  registered count value
// -----------------------------------------------------------------------------
module sat_counter
    import score_update_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == MAX_V);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/score_update.sv
// -----------------------------------------------------------------------------
// score_update
// Counts match results. A result event fires when matchresult is non-zero and
// differs from the value seen on the previous cycle, so a held code counts
// once while a direct win<->lose change counts again. Every event bumps
// round; win and lose events also bump their own counter. All counters
// saturate independently at CNT_MAX.
//
// Ports:
//   clk         in   1      rising-edge clock
//   resetn      in   1      asynchronous reset, active HIGH despite the name
//   matchresult in   2      00 none, 01 draw, 10 win, 11 lose
//   round       out  CNT_W  rounds played (draw + win + lose events)
//   win         out  CNT_W  win events
//   lose        out  CNT_W  lose events
// -----------------------------------------------------------------------------
module score_update
    import score_update_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       matchresult,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] win,
    output logic [CNT_W-1:0] lose
);

    logic [1:0] r_prev_result;
    logic       w_event;
    logic       w_inc_round;
    logic       w_inc_win;
    logic       w_inc_lose;

    // Reset value 00 makes a code already present at reset release count.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_prev_result <= RES_NONE;
        end else begin
            r_prev_result <= matchresult;
        end
    end

    assign w_event     = (matchresult != RES_NONE) && (matchresult != r_prev_result);
    assign w_inc_round = w_event;
    assign w_inc_win   = w_event && (matchresult == RES_WIN);
    assign w_inc_lose  = w_event && (matchresult == RES_LOSE);

    sat_counter #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_round (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_inc_round),
        .count  (round)
    );

    sat_counter #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_win (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_inc_win),
        .count  (win)
    );

    sat_counter #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_lose (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_inc_lose),
        .count  (lose)
    );

endmodule

// File: tb/tb_score_update.sv
// -----------------------------------------------------------------------------
// tb_score_update
// Self-checking bench for score_update: directed scenarios with literal
// expectations, then randomized result codes with occasional reset pulses,
// all continuously compared against an event-counting reference model.
// -----------------------------------------------------------------------------
module tb_score_update;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk;
    logic          resetn;
    logic [1:0]    matchresult;
    logic [CW-1:0] round;
    logic [CW-1:0] win;
    logic [CW-1:0] lose;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integer tallies.
    int m_round = 0;
    int m_win   = 0;
    int m_lose  = 0;
    int m_last  = 0;

    score_update #(
        .CNT_W   (CW),
        .CNT_MAX (CMAX)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .matchresult (matchresult),
        .round       (round),
        .win         (win),
        .lose        (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Model: an event is a non-zero code that differs from last cycle's code.
    always @(posedge clk) begin
        if (resetn) begin
            m_round = 0; m_win = 0; m_lose = 0; m_last = 0;
        end else begin
            if (matchresult != 2'b00 && int'(matchresult) != m_last) begin
                m_round = sat_inc(m_round);
                if (matchresult == 2'b10) m_win  = sat_inc(m_win);
                if (matchresult == 2'b11) m_lose = sat_inc(m_lose);
            end
            m_last = int'(matchresult);
        end
    end

    always @(posedge resetn) begin
        m_round = 0; m_win = 0; m_lose = 0; m_last = 0;
    end

    // Continuous comparison, half a period away from the active edge.
    always @(negedge clk) begin
        check("model_round", int'(round), m_round);
        check("model_win",   int'(win),   m_win);
        check("model_lose",  int'(lose),  m_lose);
    end

    // Drive a code and hold it for n rising edges; returns at edge + 2.
    task automatic hold(input logic [1:0] code, input int n);
        matchresult = code;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        hold(2'b00, 2);
        resetn = 1'b0;
    endtask

    task automatic expect3(input string name, input int r, input int w, input int l);
        check({name, "_round"}, int'(round), r);
        check({name, "_win"},   int'(win),   w);
        check({name, "_lose"},  int'(lose),  l);
    endtask

    initial begin
        resetn      = 1'b1;
        matchresult = 2'b00;
        @(posedge clk); #2;
        expect3("reset_state", 0, 0, 0);
        hold(2'b00, 1);
        resetn = 1'b0;

        // Held win counts once.
        hold(2'b10, 5);
        expect3("held_win", 1, 1, 0);

        // 10,00,11,00,01,00 each held two cycles.
        do_reset();
        hold(2'b10, 2); hold(2'b00, 2); hold(2'b11, 2);
        hold(2'b00, 2); hold(2'b01, 2); hold(2'b00, 2);
        expect3("mixed_seq", 3, 1, 1);

        // Direct win -> lose without a gap counts twice.
        do_reset();
        hold(2'b10, 2); hold(2'b11, 2);
        expect3("direct_change", 2, 1, 1);

        // Twenty wins saturate at the maximum.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            hold(2'b10, 1);
            hold(2'b00, 1);
        end
        expect3("saturate", 15, 15, 0);
        hold(2'b10, 1);
        expect3("saturate_hold", 15, 15, 0);

        // Round saturated must not block lose increments.
        hold(2'b11, 1); hold(2'b00, 1); hold(2'b11, 1);
        expect3("indep_sat", 15, 15, 2);

        // Reset released with lose already present.
        resetn = 1'b1;
        hold(2'b11, 2);
        resetn = 1'b0;
        hold(2'b11, 1);
        expect3("release_on_lose", 1, 0, 1);
        hold(2'b11, 3);
        expect3("release_on_lose_held", 1, 0, 1);

        // Asynchronous reset mid-cycle clears before the next edge.
        hold(2'b10, 1);
        expect3("pre_async", 2, 1, 1);
        resetn = 1'b1;
        #1;
        expect3("async_reset", 0, 0, 0);
        hold(2'b00, 1);
        resetn = 1'b0;

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] code;
            code = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                resetn = 1'b1;
                hold(code, int'($urandom_range(1, 2)));
                resetn = 1'b0;
            end
            hold(code, int'($urandom_range(1, 3)));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_update.md
SCORE_UPDATE -- requirements
Module: score_update

Interface
REQ-001 Parameter: CNT_W, default 4, width of every counter output.
REQ-002 Parameter: CNT_MAX, default 15, saturation value of every counter; CNT_MAX SHALL be no greater than 2^CNT_W-1.
REQ-003 Port: clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port: resetn, input, 1, reset; asynchronous and active-high (asserted when 1), despite the name.
REQ-005 Port: matchresult, input, 2, result code: 00 none, 01 draw, 10 win, 11 lose.
REQ-006 Port: round, output, CNT_W, number of rounds played (draw + win + lose events).
REQ-007 Port: win, output, CNT_W, number of win events.
REQ-008 Port: lose, output, CNT_W, number of lose events.

Function
REQ-009 The block SHALL register matchresult every cycle into an internal prev_result register (reset value 00).
REQ-010 A result event SHALL fire on a cycle where matchresult != 00 and matchresult != prev_result.
- A held code SHALL count once only.
- A direct change 10->11 or 11->10 SHALL count as a new event.
REQ-011 On an event, round SHALL increment by 1 on the same rising edge, visible one cycle after the input change.
REQ-012 On an event with code 10, win SHALL increment by 1 in the same edge as round.
REQ-013 On an event with code 11, lose SHALL increment by 1 in the same edge as round.
REQ-014 On an event with code 01 (draw), only round SHALL increment.
REQ-015 Code 00 SHALL never change any counter.
REQ-016 Every counter SHALL saturate at CNT_MAX; increments at CNT_MAX SHALL be ignored, with no wrap-around.
REQ-017 Each counter SHALL saturate independently; round at CNT_MAX SHALL NOT block win or lose increments.
REQ-018 Outputs SHALL be driven directly from registers, with no combinational path from matchresult.

Reset
REQ-019 While resetn = 1, round, win, lose and prev_result SHALL be 0 immediately, without waiting for a clock edge.
REQ-020 On the first rising edge after resetn falls, a nonzero matchresult SHALL count as an event, because prev_result = 00.
REQ-021 Reset SHALL dominate any simultaneous event, including reset asserted mid-count.

Structure
REQ-022 A shared package SHALL hold the result-code constants (RES_NONE, RES_DRAW, RES_WIN, RES_LOSE) and the default CNT_W and CNT_MAX.
REQ-023 One sub-module, sat_counter (parameters CNT_W and CNT_MAX; ports clk, resetn, inc, count), SHALL be instantiated three times: round, win and lose.
REQ-024 Event detection and code decode SHALL reside in score_update.

Verification
REQ-025 Assert resetn=1 mid-cycle with counters nonzero -> round, win and lose read 0 before the next clock edge.
REQ-026 After reset, hold matchresult=10 for 5 cycles -> round=1, win=1, lose=0.
REQ-027 Apply the sequence 10,00,11,00,01,00 with each value held 2 cycles -> round=3, win=1, lose=1.
REQ-028 Apply 10 then 11 directly, 2 cycles each, with no 00 between -> round=2, win=1, lose=1.
REQ-029 Apply alternating 10/00 for 20 wins -> win=15 and round=15, with both holding (no wrap) while lose stays 0.
REQ-030 Deassert reset while matchresult=11 is already present -> round=1 and lose=1 after the first clock edge.
